cv32e40p_apu_arbiter: RTL

CV32E40P_APU_ARBITER -- requirements
Module: cv32e40p_apu_arbiter

---
 rtl/cv32e40p_apu_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter that lets several APU requesters share one FPU.
// Results return in issue order; an in-flight tag FIFO routes each result
// back to the requester that issued it.

package cv32e40p_apu_core_pkg;
    parameter int APU_NARGS_CPU    = 3;
    parameter int APU_WOP_CPU      = 6;
    parameter int APU_NDSFLAGS_CPU = 15;
    parameter int APU_NUSFLAGS_CPU = 5;
endpackage

module cv32e40p_apu_arbiter
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NUM_REQ-1:0]                            req_i,
    output logic [NUM_REQ-1:0]                            gnt_o,
    input  logic [NUM_REQ-1:0][APU_NARGS_CPU-1:0][31:0]   operands_i,
    input  logic [NUM_REQ-1:0][APU_WOP_CPU-1:0]           op_i,
    input  logic [NUM_REQ-1:0][APU_NDSFLAGS_CPU-1:0]      flags_i,
    output logic [NUM_REQ-1:0]                            rvalid_o,
    output logic [31:0]                                   rdata_o,
    output logic [APU_NUSFLAGS_CPU-1:0]                   rflags_o,
    output logic                                          fpu_req_o,
    input  logic                                          fpu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]                fpu_operands_o,
    output logic [APU_WOP_CPU-1:0]                        fpu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]                   fpu_flags_o,
    input  logic                                          fpu_rvalid_i,
    input  logic [31:0]                                   fpu_rdata_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]                   fpu_rflags_i,
    output logic                                          busy_o,
    output logic                                          err_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] lock_idx;
    logic             locked;
    logic [IDX_W-1:0] sel;
    logic             sel_valid;
    logic             any_req;
    logic             fifo_full;
    logic             accept;
    logic             pop;
    logic             lock_drop;
    logic             err_q;

    logic [IDX_W-1:0] tag_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    assign any_req   = |req_i;
    assign fifo_full = (count == CNT_W'(MAX_OUTSTANDING));
    // A locked requester that lets go of its request forfeits the lock.
    assign lock_drop = locked & ~req_i[lock_idx];

    // Pick the requester: a live lock wins, otherwise search up from rr_ptr.
    always_comb begin
        int idx;
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        sel       = '0;
        sel_valid = 1'b0;
        idx       = 0;
        if (locked && req_i[lock_idx]) begin
            sel       = lock_idx;
            sel_valid = 1'b1;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                idx = int'(rr_ptr) + i;
                if (idx >= NUM_REQ) idx = idx - NUM_REQ;
                if (!sel_valid && req_i[idx]) begin
                    sel       = IDX_W'(idx);
                    sel_valid = 1'b1;
                end
            end
        end
    end

    // Request side: outputs are gated by reset so nothing leaks out while held.
    assign fpu_req_o      = rst_ni & any_req & ~fifo_full;
    assign accept         = fpu_req_o & fpu_gnt_i;
    assign fpu_operands_o = sel_valid ? operands_i[sel] : '0;
    assign fpu_op_o       = sel_valid ? op_i[sel]       : '0;
    assign fpu_flags_o    = sel_valid ? flags_i[sel]    : '0;

    // Grant goes only to the selected requester, in the handshake cycle.
    always_comb begin
        gnt_o = '0;
        if (accept) gnt_o[sel] = 1'b1;
    end

    // Result side: route the result to the oldest in-flight tag.
    assign pop = rst_ni & fpu_rvalid_i & (count != '0);

    always_comb begin
        rvalid_o = '0;
        if (pop) rvalid_o[tag_mem[rd_ptr]] = 1'b1;
    end

    assign rdata_o  = fpu_rdata_i;
    assign rflags_o = fpu_rflags_i;
    assign busy_o   = rst_ni & (any_req | (count != '0));
    assign err_o    = err_q;

    // Arbitration, lock, FIFO bookkeeping and sticky error state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr   <= '0;
            lock_idx <= '0;
            locked   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (accept) begin
                rr_ptr <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                locked <= 1'b0;
            end else if (fpu_req_o) begin
                locked   <= 1'b1;
                lock_idx <= sel;
            end else if (lock_drop) begin
                locked <= 1'b0;
            end

            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;

            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (lock_drop || (fpu_rvalid_i && count == '0)) err_q <= 1'b1;
        end
    end

    // Tag storage; only entries between rd_ptr and wr_ptr are ever read.
    // NOTE: the storage array is deliberately not reset; the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (accept) tag_mem[wr_ptr] <= sel;
    end

endmodule
